// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction cache.
package icache_pkg;

  // Encoding of "addi x0, x0, 0", returned whenever there is no hit.
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  localparam int unsigned DefLines        = 16;
  localparam int unsigned DefWordsPerLine = 4;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } state_e;

  // Index width for a power-of-two count; never below one bit.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side handshake signals of the instruction cache.
interface icache_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        flush;
  logic [31:0] instr;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  // The cache itself.
  modport slave (
    input  req_valid, req_addr, flush, mem_ready, mem_rvalid, mem_rdata,
    output instr, stall, mem_req, mem_addr
  );

  // Fetch stage plus backing memory.
  modport master (
    output req_valid, req_addr, flush, mem_ready, mem_rvalid, mem_rdata,
    input  instr, stall, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_data_array.sv
// Cache data words: one asynchronous read port, one synchronous write port.
module icache_data_array
  import icache_pkg::*;
#(
  parameter int unsigned LINES          = DefLines,
  parameter int unsigned WORDS_PER_LINE = DefWordsPerLine,
  localparam int unsigned AddrW         = idx_bits(LINES * WORDS_PER_LINE)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [LINES * WORDS_PER_LINE];

  // Line-fill writes land on the edge where the returned word is sampled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with a word-at-a-time line fill.
// Optional statistics counters are built when ICACHE_STATS_EN is defined.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned LINES          = DefLines,
  parameter int unsigned WORDS_PER_LINE = DefWordsPerLine
) (
  input  logic        clk,
  input  logic        rst,
  icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned OffW     = idx_bits(WORDS_PER_LINE);
  localparam int unsigned IdxW     = idx_bits(LINES);
  localparam int unsigned TagW     = 32 - 2 - OffW - IdxW;
  localparam int unsigned LastWord = WORDS_PER_LINE - 1;

  logic [OffW-1:0] req_off;
  logic [IdxW-1:0] req_idx;
  logic [TagW-1:0] req_tag;

  assign req_off = bus.req_addr[2 +: OffW];
  assign req_idx = bus.req_addr[2 + OffW +: IdxW];
  assign req_tag = bus.req_addr[31 -: TagW];

  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr[1:0];

  state_e          state_q, state_d;
  logic [31:0]     base_q, base_d;
  logic [OffW-1:0] count_q, count_d;
  logic            pend_q, pend_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TagW-1:0] tag_q [LINES];
  logic            mem_req_q, mem_req_d;
  logic [31:0]     mem_addr_q, mem_addr_d;

  logic [IdxW-1:0] fill_idx;
  logic            last_word;
  logic            hit;
  logic            fill_we;
  logic            fill_done;
  logic [31:0]     rdata;

  // The fill always targets the latched line, never the live fetch address.
  assign fill_idx  = base_q[2 + OffW +: IdxW];
  assign last_word = (count_q == OffW'(LastWord));

  assign hit = bus.req_valid & valid_q[req_idx] & (tag_q[req_idx] == req_tag) &
               (state_q == StIdle);

  assign bus.instr    = hit ? rdata : NopInstr;
  assign bus.stall    = (bus.req_valid & ~hit) | (state_q != StIdle);
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;

  // Reset masks the write so a response arriving while aborting is dropped.
  assign fill_we   = (state_q == StWait) & bus.mem_rvalid & ~rst;
  assign fill_done = fill_we & last_word;

  icache_data_array #(
    .LINES         (LINES),
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_data (
    .clk_i  (clk),
    .we_i   (fill_we),
    .waddr_i({fill_idx, count_q}),
    .wdata_i(bus.mem_rdata),
    .raddr_i({req_idx, req_off}),
    .rdata_o(rdata)
  );

  // Line-fill FSM next state, with mem_req/mem_addr computed one cycle ahead.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    pend_d     = pend_q;
    valid_d    = valid_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    unique case (state_q)
      StIdle: begin
        if (bus.flush) begin
          valid_d = '0;
        end
        if (bus.req_valid && !hit) begin
          base_d     = {bus.req_addr[31:2+OffW], {(OffW + 2){1'b0}}};
          count_d    = '0;
          state_d    = StReq;
          mem_req_d  = 1'b1;
          mem_addr_d = base_d;
        end
      end
      StReq: begin
        if (bus.flush) begin
          pend_d = 1'b1;
        end
        if (bus.mem_ready) begin
          state_d   = StWait;
          mem_req_d = 1'b0;
        end
      end
      StWait: begin
        if (bus.flush) begin
          pend_d = 1'b1;
        end
        if (bus.mem_rvalid) begin
          if (last_word) begin
            // A flush arriving on the completing cycle counts as pending too.
            if (pend_q || bus.flush) begin
              valid_d = '0;
            end else begin
              valid_d[fill_idx] = 1'b1;
            end
            pend_d  = 1'b0;
            state_d = StIdle;
          end else begin
            count_d    = count_q + 1'b1;
            state_d    = StReq;
            mem_req_d  = 1'b1;
            mem_addr_d = base_q | {{(30 - OffW){1'b0}}, count_d, 2'b00};
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      count_q    <= '0;
      pend_q     <= 1'b0;
      valid_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      valid_q    <= valid_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Tag is written with the last word; the valid bit guards it until then.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[fill_idx] <= base_q[31 -: TagW];
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Free-running wrap-around event counters.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if ((state_q == StIdle) && (state_d == StReq)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: table of hit reads plus hand-written fill sequences.
module tb_icache;

  logic clk;
  logic rst;
  icache_if bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache #(
    .LINES         (16),
    .WORDS_PER_LINE(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hC0DE_0000 ^ (a << 4) ^ 32'h0000_0F0F;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Memory model: ready whenever requested (unless held), data one cycle later.
  logic        auto_rvalid = 1'b0;
  logic        man_rvalid  = 1'b0;
  logic        seen_req    = 1'b0;
  logic [31:0] seen_addr   = '0;
  int          ready_hold  = 0;
  int          hold_seen   = 0;
  int          hold_bad    = 0;
  logic [31:0] hold_addr   = '0;
  logic [31:0] acc_q[$];

  assign bus.mem_rvalid = auto_rvalid | man_rvalid;

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (seen_req && bus.mem_ready) begin
        auto_rvalid   = 1'b1;
        bus.mem_rdata = word_of(seen_addr);
        acc_q.push_back(seen_addr);
      end else begin
        auto_rvalid = 1'b0;
      end
      seen_req  = bus.mem_req;
      seen_addr = bus.mem_addr;
      if (bus.mem_req && ready_hold > 0) begin
        if (hold_seen == 0) hold_addr = bus.mem_addr;
        else if (bus.mem_addr !== hold_addr) hold_bad++;
        bus.mem_ready = 1'b0;
        ready_hold--;
        hold_seen++;
      end else begin
        bus.mem_ready = bus.mem_req;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Presents addr, counts consecutive stall cycles, then checks the hit word.
  task automatic run_miss(input logic [31:0] a, input int exp_n, input string nm);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    #1;
    n = 0;
    while (bus.stall && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check(nm, n, exp_n);
    check({nm, "_instr"}, bus.instr, word_of(a));
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] exp_instr;
    logic        exp_stall;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    vecs[0] = '{1'b1, 32'h0000_0004, word_of(32'h4), 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0008, word_of(32'h8), 1'b0};
    vecs[2] = '{1'b1, 32'h0000_000E, word_of(32'hC), 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0000, word_of(32'h0), 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0004, 32'h0000_0013,  1'b0};

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", {31'b0, bus.stall}, 32'd0);
    check("rst_instr", bus.instr, 32'h0000_0013);
    check("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    bus.req_valid = 1'b1;
    #1;
    check("rst_stall_req", {31'b0, bus.stall}, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b0;

    // Cold miss on line 0: 9 stall cycles, words fetched in order.
    acc_q.delete();
    run_miss(32'h0, 9, "fill0");
    check("fill0_nreq", acc_q.size(), 4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
      check($sformatf("fill0_addr%0d", i), acc_q[i], 32'(4 * i));
    end

    // Hits in the filled line, and an idle cycle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.req_valid = vecs[i].valid;
      bus.req_addr  = vecs[i].addr;
      #1;
      check($sformatf("vec%0d_instr", i), bus.instr, vecs[i].exp_instr);
      check($sformatf("vec%0d_stall", i), {31'b0, bus.stall}, {31'b0, vecs[i].exp_stall});
    end

    // Tag conflict on index 0 evicts line 0.
    run_miss(32'h0000_0100, 9, "conflict");
    run_miss(32'h0000_0000, 9, "refill0");

    // Flush during WAIT of the third word: fill completes, line not kept.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0020;
    repeat (6) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    n = 0;
    while (bus.stall && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("flush_fill", n, 11);
    check("flush_instr", bus.instr, word_of(32'h20));

    // Memory stalls the first request for three cycles.
    acc_q.delete();
    ready_hold = 3;
    hold_seen  = 0;
    hold_bad   = 0;
    run_miss(32'h0000_0040, 12, "ready_hold");
    check("hold_cycles", hold_seen, 3);
    check("hold_addr_stable", hold_bad, 0);
    check("hold_first_addr", hold_addr, 32'h0000_0040);

    // Flush while idle invalidates the resident line.
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    run_miss(32'h0000_0040, 9, "idle_flush");

    // Reset in the middle of a fill, followed by stray responses.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0060;
    repeat (3) @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_stall", {31'b0, bus.stall}, 32'd0);
    check("abort_mem_req", {31'b0, bus.mem_req}, 32'd0);
`ifdef ICACHE_STATS_EN
    check("abort_hits", hit_count, 32'd0);
    check("abort_misses", miss_count, 32'd0);
`endif
    @(negedge clk);
    man_rvalid = 1'b1;
    #1;
    check("stray_stall", {31'b0, bus.stall}, 32'd0);
    check("stray_mem_req", {31'b0, bus.mem_req}, 32'd0);
    @(negedge clk);
    man_rvalid = 1'b0;
    run_miss(32'h0000_0060, 9, "after_abort");
`ifdef ICACHE_STATS_EN
    check("stat_misses", miss_count, 32'd1);
    check("stat_hits", hit_count, 32'd0);
`endif

    @(negedge clk);
    bus.req_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the fetch stage and the backing instruction memory. A hit returns the instruction in the same cycle with no stall. A miss raises `stall` (driven into fetch's icache status input) and runs a line-fill state machine against a request/response memory port. Flush supports `fence.i`.

## Interface
Parameters:
- `LINES`, default 16: number of cache lines; power of two, ≥2.
- `WORDS_PER_LINE`, default 4: 32-bit words per line; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  fetch presents an address this cycle.
- `req_addr`  in  32  byte address (PC); bits [1:0] ignored.
- `flush`  in  1  invalidate all lines.
- `instr`  out  32  instruction word.
- `stall`  out  1  fetch must hold its PC.
- `mem_req`  out  1  read request to backing memory.
- `mem_addr`  out  32  word-aligned request address.
- `mem_ready`  in  1  memory accepts the request this cycle.
- `mem_rvalid`  in  1  `mem_rdata` is valid.
- `mem_rdata`  in  32  returned word.

## Operation
Address split:
- offset = `req_addr[2 +: log2(WORDS_PER_LINE)]`.
- index = next `log2(LINES)` bits.
- tag = the remaining upper bits.

Per-line state: valid bit, tag, data words.

Hit definition: `hit = req_valid & valid[index] & (tag match) & state==IDLE`.
- On a hit, `instr` = data[index][offset].
- Otherwise `instr` = 32'h00000013 (NOP).

`stall = (req_valid & ~hit) | (state != IDLE)`.

State machine:
- **IDLE**:
  - If `req_valid & ~hit`, latch line base address (`req_addr` with offset and byte bits zeroed), clear the word counter, and go to REQ.
  - If `flush` is asserted, clear all valid bits. Flush and a miss in the same cycle: flush applies and the miss proceeds.
- **REQ**:
  - Drive `mem_req=1` and `mem_addr = base + 4*count`.
  - Hold both until `mem_ready` is sampled high, then go to WAIT.
- **WAIT**:
  - Hold `mem_req=0`.
  - When `mem_rvalid` is high, write `mem_rdata` into data[index][count].
  - If count == WORDS_PER_LINE-1: set the tag, set valid (unless a flush is pending), clear all valids if a flush is pending, and go to IDLE.
  - Otherwise increment count and go to REQ.

Rules and boundary conditions:
- Only one memory request is outstanding at a time.
- `mem_rvalid` outside WAIT is ignored.
- The earliest legal `mem_rvalid` is the cycle after acceptance.
- Fetch holds `req_addr` stable while `stall=1`. The fill uses only the latched base address, so address changes during a fill cannot corrupt it.
- `flush` during REQ/WAIT sets a pending flag. The line being filled is never marked valid, and the pending flag clears when the fill completes.
- Reset mid-fill aborts the fill immediately. The partially filled line stays invalid, and a late `mem_rvalid` is ignored.
- Reset values:
  - state = IDLE; all valid bits and the pending flag = 0.
  - `mem_req` = 0; `mem_addr` = 0.
  - `instr` = NOP.
  - `stall` = `req_valid`, because no line is valid after reset.

## Timing
- Hit: zero-cycle latency, combinational tag compare and data read. `stall` stays 0.
- Miss, with memory granting `mem_ready` immediately and returning `mem_rvalid` L cycles after acceptance:
  - `stall` is high for N·(1+L)+1 consecutive cycles, where N = WORDS_PER_LINE.
  - In the following cycle the same address hits.
  - With N=4 and L=1 this is 9 stall cycles.
- Each cycle that `mem_ready` is deasserted in REQ adds one stall cycle.
- Array writes happen at the rising edge where `mem_rvalid` is sampled in WAIT.

## Configuration
Macro `ICACHE_STATS_EN`:
- **Defined**: adds two output ports, `hit_count` (32 bits) and `miss_count` (32 bits).
  - Both reset to 0 and wrap on overflow.
  - `hit_count` increments each cycle `hit` is high.
  - `miss_count` increments on each IDLE→REQ transition.
- **Undefined**: the ports and counters do not exist; all other behaviour is identical.

## Structure
Shared package holds:
- the state enum (IDLE, REQ, WAIT);
- the NOP constant 32'h00000013;
- helper widths derived from `LINES` and `WORDS_PER_LINE`.

Sub-module `icache_data_array` holds the data words: one asynchronous read port and one synchronous write port. The tag/valid storage and the FSM stay in `icache`.

## Test plan
- Reset, then `req_addr`=0x00000000: `stall`=1 for 9 cycles (L=1). Memory sees `mem_addr` 0x0, 0x4, 0x8, 0xC in order. Next cycle `instr` = the word returned for 0x0 and `stall`=0.
- Read 0x4, 0x8, 0xC after that fill: every access hits, `stall`=0, with the correct words.
- Access 0x00000100 (same index as line 0, different tag, with LINES=16, N=4): this is a miss that refills the line. A re-read of 0x0 must miss again.
- Assert `flush` during the WAIT for the third word: the fill completes, and the next access to the same address misses.
- Hold `mem_ready`=0 for 3 cycles on the first request: `mem_req` and `mem_addr` stay stable throughout, and the stall lengthens by 3 cycles.
- Assert `rst` in the middle of a fill, then pulse `mem_rvalid`: no array write occurs, state is IDLE, and a re-access misses. With `ICACHE_STATS_EN`, the counters read 0 after the reset.
